// File: rtl/mult_wb_merge_pkg.sv
// Shared core constants and types for the multiply/exe writeback merge.
package mult_wb_merge_pkg;

  localparam int unsigned CoreXlen  = 32;
  localparam int unsigned CoreRaddr = 5;

  // RISC-V OP opcode and the M-extension funct7 that marks multiply/divide.
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

  typedef enum logic [1:0] {
    SelNone,
    SelMult,
    SelHold,
    SelExe
  } wb_sel_e;

endpackage

// File: rtl/wb_hold_entry.sv
// Single-entry holding register for an exe result displaced by a multiply writeback.
module wb_hold_entry #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic [RADDR-1:0] addr_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             full_o,
  output logic [XLEN-1:0]  data_o,
  output logic [RADDR-1:0] addr_o,
  output logic [XLEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o
);

  logic             full_q, full_d;
  logic [XLEN-1:0]  data_q, instr_q, pc_q;
  logic [RADDR-1:0] addr_q;

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_comb begin
    full_d = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q <= full_d;
      if (load_i && !clear_i) begin
        data_q  <= data_i;
        addr_q  <= addr_i;
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign full_o  = full_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/mult_wb_merge.sv
// Merges the multiply pipeline and exe results into one registered writeback port.
module mult_wb_merge
  import mult_wb_merge_pkg::*;
#(
  parameter int unsigned XLEN  = CoreXlen,
  parameter int unsigned RADDR = CoreRaddr
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             kill_i,
  input  logic [XLEN-1:0]  mult5_int_write_data_i,
  input  logic [RADDR-1:0] mult5_write_addr_i,
  input  logic             mult5_int_write_enable_i,
  input  logic [XLEN-1:0]  mult5_instruction_i,
  input  logic [XLEN-1:0]  mult5_pc_i,
  input  logic [XLEN-1:0]  exe_int_write_data_i,
  input  logic [RADDR-1:0] exe_write_addr_i,
  input  logic             exe_int_write_enable_i,
  input  logic [XLEN-1:0]  exe_instruction_i,
  input  logic [XLEN-1:0]  exe_pc_i,
  output logic [XLEN-1:0]  wb_int_write_data_o,
  output logic [RADDR-1:0] wb_write_addr_o,
  output logic             wb_int_write_enable_o,
  output logic [XLEN-1:0]  wb_instruction_o,
  output logic [XLEN-1:0]  wb_pc_o,
  output logic             exe_stall_o
);

  logic             hold_full, hold_load, hold_clear;
  logic [XLEN-1:0]  hold_data, hold_instr, hold_pc;
  logic [RADDR-1:0] hold_addr;
  logic             exe_valid;
  wb_sel_e          sel;

  logic [XLEN-1:0]  wb_data_q, wb_data_d, wb_instr_q, wb_instr_d, wb_pc_q, wb_pc_d;
  logic [RADDR-1:0] wb_addr_q, wb_addr_d;
  logic             wb_we_q, wb_we_d;

  // Exe inputs are ignored while stalled and discarded on a flush.
  assign exe_valid = exe_int_write_enable_i & ~hold_full & ~kill_i;

  // An x0 exe result is never parked: it would write nothing anyway.
  assign hold_load  = mult5_int_write_enable_i & exe_valid & (exe_write_addr_i != '0);
  assign hold_clear = kill_i | (hold_full & ~mult5_int_write_enable_i);

  always_comb begin
    sel = SelNone;
    if (mult5_int_write_enable_i) begin
      sel = SelMult;
    end else if (hold_full && !kill_i) begin
      sel = SelHold;
    end else if (exe_valid) begin
      sel = SelExe;
    end
  end

  always_comb begin
    wb_data_d  = '0;
    wb_addr_d  = '0;
    wb_instr_d = '0;
    wb_pc_d    = '0;
    unique case (sel)
      SelMult: begin
        wb_data_d  = mult5_int_write_data_i;
        wb_addr_d  = mult5_write_addr_i;
        wb_instr_d = mult5_instruction_i;
        wb_pc_d    = mult5_pc_i;
      end
      SelHold: begin
        wb_data_d  = hold_data;
        wb_addr_d  = hold_addr;
        wb_instr_d = hold_instr;
        wb_pc_d    = hold_pc;
      end
      default: begin
        if (!hold_full) begin
          wb_data_d  = exe_int_write_data_i;
          wb_addr_d  = exe_write_addr_i;
          wb_instr_d = exe_instruction_i;
          wb_pc_d    = exe_pc_i;
        end
      end
    endcase
    wb_we_d = (sel != SelNone) && (wb_addr_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_instr_q <= '0;
      wb_pc_q    <= '0;
    end else begin
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      wb_we_q    <= wb_we_d;
      wb_instr_q <= wb_instr_d;
      wb_pc_q    <= wb_pc_d;
    end
  end

  wb_hold_entry #(
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_hold (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  (exe_int_write_data_i),
    .addr_i  (exe_write_addr_i),
    .instr_i (exe_instruction_i),
    .pc_i    (exe_pc_i),
    .full_o  (hold_full),
    .data_o  (hold_data),
    .addr_o  (hold_addr),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  assign wb_int_write_data_o   = wb_data_q;
  assign wb_write_addr_o       = wb_addr_q;
  assign wb_int_write_enable_o = wb_we_q;
  assign wb_instruction_o      = wb_instr_q;
  assign wb_pc_o               = wb_pc_q;
  assign exe_stall_o           = hold_full;

endmodule
